// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the shared popcount scheduler.
// Pure declarations: no latency, no flow control.
package popcount_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, RESP} state_t;

  localparam int NREQ_DEF  = 4;
  localparam int W_DEF     = 128;
  localparam int CHUNK_DEF = 32;

  // Width able to hold the value w itself, not just 0..w-1.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice.
// Zero latency, no flow control.
module popcount_chunk #(
  parameter int CHUNK = 32
) (
  input  logic [CHUNK-1:0]       chunk_i,
  output logic [$clog2(CHUNK):0] count_o
);

  localparam int OW = $clog2(CHUNK) + 1;

  logic [OW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum = sum + OW'(chunk_i[i]);
    end
  end

  assign count_o = sum;

endmodule

// File: rtl/popcount_sched.sv
// Round-robin shared popcount: one word per transaction, CHUNK bits/cycle, rsp_valid W/CHUNK cycles after accept.
// Holds the result while rsp_ready is low; no request is accepted outside IDLE.
module popcount_sched
  import popcount_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int W     = W_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*W-1:0]        req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [$clog2(W):0]       rsp_count,
  output logic                     busy
);

  localparam int NCHUNK = W / CHUNK;
  localparam int CW     = cnt_width(W);
  localparam int IDW    = $clog2(NREQ);
  localparam int CNTW   = idx_width(NCHUNK);
  localparam int PCW    = $clog2(CHUNK) + 1;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [PCW-1:0]  chunk_cnt;
  logic [NREQ-1:0] ready_raw;
  logic            grant_vld;
  logic [IDW-1:0]  winner;

  popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
    .chunk_i (shreg_q[CHUNK-1:0]),
    .count_o (chunk_cnt)
  );

  // Search starts one past the previous winner so every holder is reached within NREQ grants.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    winner    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        winner    = IDW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    count_d   = count_q;
    shreg_d   = shreg_q;
    id_d      = id_q;
    last_d    = last_q;
    ready_raw = '0;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          ready_raw[winner] = 1'b1;
          shreg_d = req_data[winner*W +: W];
          id_d    = winner;
          last_d  = winner;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        acc_d   = acc_q + CW'(chunk_cnt);
        shreg_d = shreg_q >> CHUNK;
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(NCHUNK - 1)) begin
          count_d = acc_d;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      shreg_q <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  // Gated so no requester sees an accept strobe while the block is held in reset.
  assign req_ready = ready_raw & {NREQ{nrst}};
  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = id_q;
  assign rsp_count = count_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_popcount_sched.sv
// Scoreboard bench for popcount_sched: stimulus queues expected {id,count}, a negedge monitor pops on each handshake.
module tb_popcount_sched;

  localparam int NREQ = 4;
  localparam int W    = 128;

  logic              clk = 1'b0;
  logic              nrst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [7:0]        rsp_count;
  logic              busy;

  always #5 clk = ~clk;

  popcount_sched #(.NREQ(NREQ), .W(W), .CHUNK(32)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_count (rsp_count),
    .busy      (busy)
  );

  typedef struct {int id; int cnt;} exp_t;
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input int cnt);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] w);
    req_data[i*W +: W] = w;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_busy"},      int'(busy), 0);
    check({tag, "_rsp_id"},    int'(rsp_id), 0);
    check({tag, "_rsp_count"}, int'(rsp_count), 0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || rsp_valid) && n < 50) begin
      step();
      n++;
    end
    check("idle_within_bound", int'(n < 50), 1);
  endtask

  // Wait for rsp_valid after an accept edge, confirming busy stays high and the latency is 4.
  task automatic wait_rsp(input string tag);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      check({tag, "_busy_during_count"}, int'(busy), 1);
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
  endtask

  task automatic single(input int id, input logic [W-1:0] w, input int exp_cnt, input string tag);
    set_word(id, w);
    req_valid = NREQ'(1) << id;
    push(id, exp_cnt);
    #1;
    check({tag, "_req_ready"}, int'(req_ready), 1 << id);
    step();
    req_valid = '0;
    #1;
    check({tag, "_ready_after_accept"}, int'(req_ready), 0);
    wait_rsp(tag);
    wait_idle();
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    step();
    step();
    nrst = 1'b1;
    step();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (nrst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got id=%0d count=%0d, expected no response", rsp_id, rsp_count);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", int'(rsp_id), e.id);
        check("rsp_count", int'(rsp_count), e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] pat6;
    int           last_cyc;
    int           n;
    int           order[5];

    order     = '{0, 1, 2, 3, 0};
    last_cyc  = 0;
    pat6      = '0;
    pat6[0]   = 1'b1;
    pat6[31]  = 1'b1;
    pat6[32]  = 1'b1;
    pat6[63]  = 1'b1;
    pat6[64]  = 1'b1;
    pat6[127] = 1'b1;

    nrst      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #1;
    check_zero_outputs("reset");
    step();
    step();
    nrst = 1'b1;
    step();
    check_zero_outputs("post_reset");

    // All ones, then a zero word.
    single(0, '1, 128, "all_ones");
    single(1, '0, 0, "zero_word");

    // Round-robin under continuous contention, from a fresh pointer.
    do_reset();
    set_word(0, 128'h1);
    set_word(1, 128'h3);
    set_word(2, 128'h7);
    set_word(3, 128'h0000_0001_0000_0001_0000_0001_0000_0001);
    push(0, 1); push(1, 2); push(2, 3); push(3, 4); push(0, 1);
    req_valid = '1;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == '0 && n < 20) begin
        step();
        n++;
      end
      check("rr_grant", int'(req_ready), 1 << order[g]);
      if (g > 0) check("rr_spacing", cyc - last_cyc, 6);
      last_cyc = cyc;
      step();
      if (g == 4) req_valid = '0;
    end
    wait_idle();

    // Chunk boundaries and alternating pattern; pointer is at 0 so 2 then 3 win.
    single(2, pat6, 6, "chunk_bounds");
    single(3, {32{4'hA}}, 64, "alt_pattern");

    // Backpressure with other requesters waiting.
    rsp_ready = 1'b0;
    set_word(1, 128'hF0);
    req_valid = 4'b0010;
    push(1, 4);
    #1;
    check("bp_grant", int'(req_ready), 4'b0010);
    step();
    req_valid = 4'b1101;
    wait_rsp("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp_rsp_valid", int'(rsp_valid), 1);
      check("bp_rsp_id", int'(rsp_id), 1);
      check("bp_rsp_count", int'(rsp_count), 4);
      check("bp_req_ready", int'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_released_busy", int'(busy), 0);
    check("bp_released_valid", int'(rsp_valid), 0);
    check("bp_count_held", int'(rsp_count), 4);
    check("bp_id_held", int'(rsp_id), 1);
    check("bp_next_grant", int'(req_ready), 4'b0100);
    push(2, 6);
    step();
    req_valid = '0;
    wait_idle();

    // Reset during the second COUNT cycle aborts the transaction.
    req_valid = 4'b1000;
    #1;
    check("abort_grant", int'(req_ready), 4'b1000);
    step();
    req_valid = '0;
    step();
    nrst      = 1'b0;
    req_valid = '1;
    #1;
    check_zero_outputs("abort");
    step();
    step();
    set_word(0, 128'hFF);
    push(0, 8);
    nrst = 1'b1;
    #1;
    check("abort_first_grant", int'(req_ready), 4'b0001);
    step();
    req_valid = '0;
    wait_rsp("after_abort");
    wait_idle();
    step();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
